// File: rtl/alu_key_ctrl_if.sv
// Bundle between the key controller and the board: raw keys, switches,
// the ALU result coming back, and the operand/status lines going out.
interface alu_key_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             key_inc_n;
    logic             key_dec_n;
    logic             key_load_n;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] lamps;
    logic             opcode;
    logic [WIDTH-1:0] accum;
    logic             busy;
    logic             err;

    // Board / ALU side: drives keys, switches and the ALU result.
    modport master (
        output key_inc_n,
        output key_dec_n,
        output key_load_n,
        output sw,
        output lamps,
        input  opcode,
        input  accum,
        input  busy,
        input  err
    );

    // Controller side.
    modport slave (
        input  key_inc_n,
        input  key_dec_n,
        input  key_load_n,
        input  sw,
        input  lamps,
        output opcode,
        output accum,
        output busy,
        output err
    );
endinterface

// File: rtl/alu_key_ctrl.sv
// Push-button front end for the board ALU: sync, debounce and edge-detect three keys,
// then run one closed-loop ALU operation per press. Optional macro: ALU_KEY_CTRL_SAT_EN.
module alu_key_ctrl #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_key_ctrl_if.slave bus
);
    localparam int CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int NKEYS    = 3;
    localparam int KEY_INC  = 0;
    localparam int KEY_DEC  = 1;
    localparam int KEY_LOAD = 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Key levels are active-low: a 1 everywhere in this pipeline means released.
    logic [NKEYS-1:0] sync1_q, sync1_d;
    logic [NKEYS-1:0] sync2_q, sync2_d;
    logic [NKEYS-1:0] deb_q, deb_d;
    logic [NKEYS-1:0] deb_dly_q, deb_dly_d;
    logic [CW-1:0]    cnt_q [NKEYS];
    logic [CW-1:0]    cnt_d [NKEYS];
    logic [NKEYS-1:0] press_s;

    state_t           state_q, state_d;
    logic             opcode_q, opcode_d;
    logic [WIDTH-1:0] accum_q, accum_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    // Synchronizer and debounce next-state for all three keys.
    always_comb begin
        sync1_d   = {bus.key_load_n, bus.key_dec_n, bus.key_inc_n};
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_dly_d = deb_q;
        for (int i = 0; i < NKEYS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // One-cycle pulse on a debounced released -> pressed transition.
    always_comb begin
        press_s = deb_dly_q & ~deb_q;
    end

    // Conditioning pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= {NKEYS{1'b1}};
            sync2_q   <= {NKEYS{1'b1}};
            deb_q     <= {NKEYS{1'b1}};
            deb_dly_q <= {NKEYS{1'b1}};
            for (int i = 0; i < NKEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            for (int i = 0; i < NKEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Operation FSM: decode in IDLE, hold operands for the ALU, capture, wait for release.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        accum_d  = accum_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (press_s[KEY_LOAD]) begin
                    accum_d = bus.sw;
                    err_d   = 1'b0;
                    state_d = RELEASE;
                end else if (press_s[KEY_INC] && press_s[KEY_DEC]) begin
                    state_d = RELEASE;
                end else if (press_s[KEY_INC]) begin
`ifdef ALU_KEY_CTRL_SAT_EN
                    if (&accum_q) begin
                        err_d   = 1'b1;
                        state_d = RELEASE;
                    end else begin
                        opcode_d = 1'b0;
                        err_d    = 1'b0;
                        state_d  = ISSUE;
                    end
`else
                    opcode_d = 1'b0;
                    state_d  = ISSUE;
`endif
                end else if (press_s[KEY_DEC]) begin
`ifdef ALU_KEY_CTRL_SAT_EN
                    if (accum_q == {WIDTH{1'b0}}) begin
                        err_d   = 1'b1;
                        state_d = RELEASE;
                    end else begin
                        opcode_d = 1'b1;
                        err_d    = 1'b0;
                        state_d  = ISSUE;
                    end
`else
                    opcode_d = 1'b1;
                    state_d  = ISSUE;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                accum_d = bus.lamps;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (&deb_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RELEASE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy is computed from next-state values so the flop tracks the live condition.
    always_comb begin
        busy_d = (state_d != IDLE) || (deb_d != {NKEYS{1'b1}});
    end

    // FSM and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            opcode_q <= 1'b0;
            accum_q  <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            accum_q  <= accum_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign bus.opcode = opcode_q;
    assign bus.accum  = accum_q;
    assign bus.busy   = busy_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_alu_key_ctrl.sv
// Directed bench for alu_key_ctrl with a registered +/-1 ALU model closing the loop.
module tb_alu_key_ctrl;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    alu_key_ctrl_if #(.WIDTH(16)) bus ();

    alu_key_ctrl #(.WIDTH(16), .DEBOUNCE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board ALU model, reset by ~rst_n = rst.
    always_ff @(posedge clk) begin
        if (rst) bus.lamps <= 16'h0000;
        else     bus.lamps <= bus.opcode ? (bus.accum - 16'd1) : (bus.accum + 16'd1);
    end

    typedef struct {
        string       name;
        logic [2:0]  keys;      // bit0 inc, bit1 dec, bit2 load
        logic [15:0] sw;
        logic [15:0] exp_accum;
        logic        exp_opcode;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 80) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic press_op(input logic [2:0] keys, input logic [15:0] swv, input string name);
        bus.sw         = swv;
        bus.key_inc_n  = ~keys[0];
        bus.key_dec_n  = ~keys[1];
        bus.key_load_n = ~keys[2];
        repeat (14) tick();
        bus.key_inc_n  = 1'b1;
        bus.key_dec_n  = 1'b1;
        bus.key_load_n = 1'b1;
        wait_idle(name);
    endtask

    logic [15:0] prev;
    logic [15:0] old;
    int          changes;
    int          first;
    logic        busy_seen;

    initial begin
        tests = 0;
        fails = 0;
        bus.key_inc_n  = 1'b1;
        bus.key_dec_n  = 1'b1;
        bus.key_load_n = 1'b1;
        bus.sw         = 16'h0000;

        vecs[0]  = '{"inc1",   3'b001, 16'h0000, 16'h0001, 1'b0, 1'b0};
        vecs[1]  = '{"inc2",   3'b001, 16'h0000, 16'h0002, 1'b0, 1'b0};
        vecs[2]  = '{"dec1",   3'b010, 16'h0000, 16'h0001, 1'b1, 1'b0};
        vecs[3]  = '{"load1",  3'b100, 16'h1234, 16'h1234, 1'b1, 1'b0};
        vecs[4]  = '{"dec2",   3'b010, 16'h0000, 16'h1233, 1'b1, 1'b0};
        vecs[5]  = '{"inc3",   3'b001, 16'h0000, 16'h1234, 1'b0, 1'b0};
        vecs[6]  = '{"loadmx", 3'b100, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
`ifdef ALU_KEY_CTRL_SAT_EN
        vecs[7]  = '{"incmax", 3'b001, 16'h0000, 16'hFFFF, 1'b0, 1'b1};
        vecs[8]  = '{"decmx",  3'b010, 16'h0000, 16'hFFFE, 1'b1, 1'b0};
        vecs[9]  = '{"both",   3'b011, 16'h0000, 16'hFFFE, 1'b1, 1'b0};
        vecs[10] = '{"load0",  3'b100, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{"dec0",   3'b010, 16'h0000, 16'h0000, 1'b1, 1'b1};
        vecs[12] = '{"inc0",   3'b001, 16'h0000, 16'h0001, 1'b0, 1'b0};
`else
        vecs[7]  = '{"incmax", 3'b001, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[8]  = '{"decmx",  3'b010, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
        vecs[9]  = '{"both",   3'b011, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
        vecs[10] = '{"load0",  3'b100, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{"dec0",   3'b010, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
        vecs[12] = '{"inc0",   3'b001, 16'h0000, 16'h0000, 1'b0, 1'b0};
`endif

        // Reset state.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_opcode", {31'd0, bus.opcode}, 32'd0);
        chk("rst_accum",  {16'd0, bus.accum},  32'h0000);
        chk("rst_busy",   {31'd0, bus.busy},   32'd0);
        chk("rst_err",    {31'd0, bus.err},    32'd0);

        // Table of single operations, each from IDLE.
        for (int i = 0; i < 13; i++) begin
            press_op(vecs[i].keys, vecs[i].sw, vecs[i].name);
            chk({vecs[i].name, "_accum"},  {16'd0, bus.accum},  {16'd0, vecs[i].exp_accum});
            chk({vecs[i].name, "_opcode"}, {31'd0, bus.opcode}, {31'd0, vecs[i].exp_opcode});
            chk({vecs[i].name, "_err"},    {31'd0, bus.err},    {31'd0, vecs[i].exp_err});
        end

        // Long inc press: exactly one op, 9 cycles from key edge (2 sync + 4 debounce + 1 + 2).
        press_op(3'b100, 16'h0100, "pre_lat");
        old = bus.accum;
        prev = old;
        changes = 0;
        first = 0;
        bus.key_inc_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 5) chk("lat_busy_lo", {31'd0, bus.busy}, 32'd0);
            if (k == 6) chk("lat_busy_hi", {31'd0, bus.busy}, 32'd1);
            if (bus.accum !== prev) begin
                changes++;
                if (first == 0) first = k;
            end
            prev = bus.accum;
        end
        bus.key_inc_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.accum !== prev) changes++;
            prev = bus.accum;
        end
        chk("lat_first",   first,   9);
        chk("lat_changes", changes, 1);
        chk("lat_accum",   {16'd0, bus.accum}, {16'd0, old + 16'd1});
        chk("lat_busy_end", {31'd0, bus.busy}, 32'd0);

        // Bouncing key never stays low long enough to register.
        old = bus.accum;
        busy_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            bus.key_inc_n = k[1];
            tick();
            if (bus.busy) busy_seen = 1'b1;
        end
        bus.key_inc_n = 1'b1;
        repeat (20) begin
            tick();
            if (bus.busy) busy_seen = 1'b1;
        end
        chk("bounce_accum", {16'd0, bus.accum}, {16'd0, old});
        chk("bounce_busy",  {31'd0, busy_seen}, 32'd0);

        // Dec pressed while inc is still held is dropped.
        old = bus.accum;
        bus.key_inc_n = 1'b0;
        repeat (15) tick();
        bus.key_dec_n = 1'b0;
        repeat (15) tick();
        bus.key_dec_n = 1'b1;
        repeat (10) tick();
        chk("held_busy", {31'd0, bus.busy}, 32'd1);
        bus.key_inc_n = 1'b1;
        wait_idle("held");
        chk("held_accum",  {16'd0, bus.accum}, {16'd0, old + 16'd1});
        chk("held_opcode", {31'd0, bus.opcode}, 32'd0);

        // Reset during the ISSUE cycle of a dec aborts it.
        press_op(3'b100, 16'h00AB, "pre_abort");
        chk("abort_pre", {16'd0, bus.accum}, 32'h00AB);
        bus.key_dec_n = 1'b0;
        repeat (7) tick();
        chk("abort_issue_op", {31'd0, bus.opcode}, 32'd1);
        rst = 1'b1;
        bus.key_dec_n = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("abort_accum",  {16'd0, bus.accum}, 32'h0000);
        chk("abort_opcode", {31'd0, bus.opcode}, 32'd0);
        chk("abort_busy",   {31'd0, bus.busy}, 32'd0);
        repeat (20) tick();
        chk("abort_nocap", {16'd0, bus.accum}, 32'h0000);
        press_op(3'b001, 16'h0000, "post_abort");
        chk("post_abort_accum", {16'd0, bus.accum}, 32'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
